// File: rtl/bar_draw_scheduler.sv
// Round-robin scheduler that serialises horizontal bar-row draws from several animators onto one pixel-plot port.
// Optional build macro: GRADIENT_COLOUR_EN selects row-based colouring instead of per-bar colouring.
module bar_draw_scheduler #(
    parameter int NUM_BARS  = 4,
    parameter int BAR_WIDTH = 8,
    parameter int BAR_PITCH = 10,
    parameter int X_BASE    = 0,
    parameter int Y_TOP     = 21,
    parameter int Y_BOTTOM  = 73
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [NUM_BARS-1:0]   req,
    input  logic [NUM_BARS-1:0]   erase,
    input  logic [7*NUM_BARS-1:0] y_in,
    input  logic                  plot_ready,
    output logic [NUM_BARS-1:0]   ack,
    output logic                  busy,
    output logic                  plot,
    output logic [7:0]            x_out,
    output logic [6:0]            y_out,
    output logic [2:0]            colour_out
);

    localparam int IDX_W = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;
    localparam int COL_W = (BAR_WIDTH > 1) ? $clog2(BAR_WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t             state_r;
    logic [IDX_W-1:0]   last_grant_r;
    logic [IDX_W-1:0]   idx_r;
    logic [COL_W-1:0]   col_r;

    logic               grant_found_s;
    logic [IDX_W-1:0]   grant_idx_s;
    logic [IDX_W-1:0]   cand_idx_s;
    int                 cand_v;
    logic [6:0]         y_raw_s;
    logic [6:0]         y_clamp_s;

`ifdef GRADIENT_COLOUR_EN
    function automatic logic [2:0] pixel_colour_f(input logic erase_v, input logic [6:0] y_v);
        logic [2:0] c;
        if (erase_v) begin
            c = 3'b000;
        end else if (y_v < 7'd38) begin
            c = 3'b100;
        end else if (y_v < 7'd56) begin
            c = 3'b110;
        end else begin
            c = 3'b010;
        end
        return c;
    endfunction
`else
    function automatic logic [2:0] pixel_colour_f(input logic erase_v, input logic [IDX_W-1:0] idx_v);
        logic [2:0] c;
        if (erase_v) begin
            c = 3'b000;
        end else begin
            c = 3'((int'(idx_v) % 7) + 1);
        end
        return c;
    endfunction
`endif

    // Round-robin search starting one past the last served bar.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        cand_v        = 0;
        cand_idx_s    = '0;
        for (int k = 1; k <= NUM_BARS; k++) begin
            cand_v     = (int'(last_grant_r) + k) % NUM_BARS;
            cand_idx_s = IDX_W'(cand_v);
            if (!grant_found_s && req[cand_idx_s]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_idx_s;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Row limit clamp of the granted bar's requested y.
    always_comb begin
        y_raw_s = y_in[int'(grant_idx_s)*7 +: 7];
        if (y_raw_s < 7'(Y_TOP)) begin
            y_clamp_s = 7'(Y_TOP);
        end else if (y_raw_s > 7'(Y_BOTTOM)) begin
            y_clamp_s = 7'(Y_BOTTOM);
        end else begin
            y_clamp_s = y_raw_s;
        end
    end

    // Scheduler FSM with all pixel and handshake outputs registered.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r      <= ST_IDLE;
            last_grant_r <= IDX_W'(NUM_BARS - 1);
            idx_r        <= '0;
            col_r        <= '0;
            plot         <= 1'b0;
            ack          <= '0;
            busy         <= 1'b0;
            x_out        <= 8'd0;
            y_out        <= 7'(Y_TOP);
            colour_out   <= 3'b000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_found_s) begin
                        idx_r      <= grant_idx_s;
                        col_r      <= '0;
                        x_out      <= 8'(X_BASE + int'(grant_idx_s) * BAR_PITCH);
                        y_out      <= y_clamp_s;
`ifdef GRADIENT_COLOUR_EN
                        colour_out <= pixel_colour_f(erase[grant_idx_s], y_clamp_s);
`else
                        colour_out <= pixel_colour_f(erase[grant_idx_s], grant_idx_s);
`endif
                        plot       <= 1'b1;
                        busy       <= 1'b1;
                        state_r    <= ST_DRAW;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_DRAW: begin
                    // A pixel only counts once the downstream has taken it.
                    if (plot_ready) begin
                        if (col_r == COL_W'(BAR_WIDTH - 1)) begin
                            plot    <= 1'b0;
                            ack     <= NUM_BARS'(1'b1) << idx_r;
                            state_r <= ST_ACK;
                        end else begin
                            col_r   <= col_r + 1'b1;
                            x_out   <= x_out + 8'd1;
                        end
                    end else begin
                        state_r <= ST_DRAW;
                    end
                end
                ST_ACK: begin
                    ack          <= '0;
                    busy         <= 1'b0;
                    last_grant_r <= idx_r;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    plot    <= 1'b0;
                    ack     <= '0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bar_draw_scheduler.sv
// Directed testbench for bar_draw_scheduler: arbitration order, pixel stream, stall, clamp, erase, reset abort.
module tb_bar_draw_scheduler;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [3:0]  req;
    logic [3:0]  erase;
    logic [27:0] y_in;
    logic        plot_ready;
    logic [3:0]  ack;
    logic        busy;
    logic        plot;
    logic [7:0]  x_out;
    logic [6:0]  y_out;
    logic [2:0]  colour_out;

    int n_vec = 0;
    int n_err = 0;

    bar_draw_scheduler dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .req        (req),
        .erase      (erase),
        .y_in       (y_in),
        .plot_ready (plot_ready),
        .ack        (ack),
        .busy       (busy),
        .plot       (plot),
        .x_out      (x_out),
        .y_out      (y_out),
        .colour_out (colour_out)
    );

    always #5 Clock = ~Clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_y(input int y);
        if (y < 21) return 21;
        else if (y > 73) return 73;
        else return y;
    endfunction

    function automatic logic [2:0] exp_colour(input int bar, input int y, input bit er);
        if (er) return 3'b000;
`ifdef GRADIENT_COLOUR_EN
        if (y < 38) return 3'b100;
        else if (y < 56) return 3'b110;
        else return 3'b010;
`else
        return 3'((bar % 7) + 1);
`endif
    endfunction

    task automatic set_bar(input int bar, input int y, input bit er);
        y_in[bar*7 +: 7] = 7'(y);
        erase[bar]       = er;
    endtask

    task automatic apply_reset();
        Reset = 1'b1;
        req   = 4'b0000;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    task automatic wait_plot();
        int waited = 0;
        while (plot !== 1'b1 && waited < 20) begin
            @(negedge Clock);
            waited++;
        end
        check_val("grant_plot", 32'(plot), 32'd1);
    endtask

    // Follows one full row from grant to ack; stall_col < 0 means no stall.
    task automatic draw_row(input int bar, input int y, input bit er, input int stall_col);
        int x0 = bar * 10;
        wait_plot();
        for (int c = 0; c < 8; c++) begin
            if (c == stall_col) begin
                plot_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    check_val("stall_x", 32'(x_out), 32'(x0 + c));
                    check_val("stall_plot", 32'(plot), 32'd1);
                    @(negedge Clock);
                end
                plot_ready = 1'b1;
            end
            check_val("pix_x", 32'(x_out), 32'(x0 + c));
            check_val("pix_y", 32'(y_out), 32'(exp_y(y)));
            check_val("pix_colour", 32'(colour_out), 32'(exp_colour(bar, exp_y(y), er)));
            check_val("pix_plot", 32'(plot), 32'd1);
            check_val("pix_busy", 32'(busy), 32'd1);
            @(negedge Clock);
        end
        check_val("ack_pulse", 32'(ack), 32'(4'b0001 << bar));
        check_val("ack_plot", 32'(plot), 32'd0);
        check_val("ack_busy", 32'(busy), 32'd1);
        req[bar] = 1'b0;
        @(negedge Clock);
        check_val("ack_clear", 32'(ack), 32'd0);
        check_val("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        req        = 4'b0000;
        erase      = 4'b0000;
        y_in       = 28'd0;
        plot_ready = 1'b1;
        apply_reset();
        check_val("rst_plot", 32'(plot), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_ack", 32'(ack), 32'd0);
        check_val("rst_x", 32'(x_out), 32'd0);
        check_val("rst_y", 32'(y_out), 32'd21);
        check_val("rst_colour", 32'(colour_out), 32'd0);

        // Single bar1 row at y=40.
        set_bar(1, 40, 1'b0);
        req = 4'b0010;
        draw_row(1, 40, 1'b0, -1);

        // Round-robin ordering and pointer wrap.
        apply_reset();
        set_bar(1, 50, 1'b0);
        set_bar(2, 60, 1'b0);
        req = 4'b0110;
        draw_row(1, 50, 1'b0, -1);
        draw_row(2, 60, 1'b0, -1);
        set_bar(0, 30, 1'b0);
        set_bar(1, 35, 1'b0);
        req = 4'b0011;
        draw_row(0, 30, 1'b0, -1);
        draw_row(1, 35, 1'b0, -1);

        // Three-cycle downstream stall at col 4.
        set_bar(3, 45, 1'b0);
        req = 4'b1000;
        draw_row(3, 45, 1'b0, 4);

        // Clamp to both row limits, erase colour.
        set_bar(0, 5, 1'b0);
        req = 4'b0001;
        draw_row(0, 5, 1'b0, -1);
        set_bar(3, 100, 1'b1);
        req = 4'b1000;
        draw_row(3, 100, 1'b1, -1);

        // Reset mid-row aborts the draw and restores bar0 priority.
        set_bar(2, 45, 1'b0);
        req = 4'b0100;
        wait_plot();
        check_val("abort_colour", 32'(colour_out), 32'(exp_colour(2, 45, 1'b0)));
        repeat (3) @(negedge Clock);
        check_val("abort_x", 32'(x_out), 32'd23);
        Reset = 1'b1;
        @(negedge Clock);
        check_val("abort_plot", 32'(plot), 32'd0);
        check_val("abort_busy", 32'(busy), 32'd0);
        check_val("abort_ack", 32'(ack), 32'd0);
        Reset = 1'b0;
        req   = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            check_val("abort_no_ack", 32'(ack), 32'd0);
        end
        set_bar(0, 30, 1'b0);
        set_bar(2, 60, 1'b0);
        req = 4'b0101;
        draw_row(0, 30, 1'b0, -1);
        draw_row(2, 60, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
